// File: rtl/vga_timing_driver.sv
// VGA timing generator: pixel-address outputs plus registered HS/VS/colour with blanking.
// Optional build macro VGA_BORDER_EN paints the outermost visible pixels white.
module vga_timing_driver #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [11:0] COLOUR_IN,
    output logic [9:0]  ADDRH,
    output logic [8:0]  ADDRV,
    output logic [11:0] COLOUR_OUT,
    output logic        HS,
    output logic        VS,
    output logic        FRAME_START
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    localparam logic [9:0] HVis    = 10'(H_VIS);
    localparam logic [9:0] HSyncS  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HSyncE  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] HTotM1  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VVis    = 10'(V_VIS);
    localparam logic [9:0] VSyncS  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VSyncE  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] VTotM1  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic [DivW-1:0] r_div_cnt;
    logic [9:0]      r_h_cnt;
    logic [9:0]      r_v_cnt;
    logic            r_hs;
    logic            r_vs;
    logic [11:0]     r_colour;

    logic        w_pix_en;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_h_vis;
    logic        w_v_vis;
    logic        w_visible;
    logic        w_hs_act;
    logic        w_vs_act;
    logic [11:0] w_colour_d;

    assign w_pix_en  = (r_div_cnt == DivMax);
    assign w_h_last  = (r_h_cnt == HTotM1);
    assign w_v_last  = (r_v_cnt == VTotM1);
    assign w_h_vis   = (r_h_cnt < HVis);
    assign w_v_vis   = (r_v_cnt < VVis);
    assign w_visible = w_h_vis && w_v_vis;
    assign w_hs_act  = (r_h_cnt >= HSyncS) && (r_h_cnt < HSyncE);
    assign w_vs_act  = (r_v_cnt >= VSyncS) && (r_v_cnt < VSyncE);

    // Addresses come straight from the counters so the renderer sees them a full pixel early.
    assign ADDRH       = w_h_vis ? r_h_cnt : 10'd0;
    assign ADDRV       = w_v_vis ? r_v_cnt[8:0] : 9'd0;
    assign FRAME_START = w_pix_en && w_h_last && w_v_last;

    assign HS         = r_hs;
    assign VS         = r_vs;
    assign COLOUR_OUT = r_colour;

    always_comb begin
        w_colour_d = 12'h000;
        if (w_visible) begin
            w_colour_d = COLOUR_IN;
`ifdef VGA_BORDER_EN
            if ((r_h_cnt == 10'd0) || (r_h_cnt == HVis - 10'd1) ||
                (r_v_cnt == 10'd0) || (r_v_cnt == VVis - 10'd1)) begin
                w_colour_d = 12'hFFF;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div_cnt <= '0;
            r_h_cnt   <= 10'd0;
            r_v_cnt   <= 10'd0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_colour  <= 12'h000;
        end else begin
            r_div_cnt <= w_pix_en ? '0 : r_div_cnt + DivW'(1);
            if (w_pix_en) begin
                r_h_cnt <= w_h_last ? 10'd0 : r_h_cnt + 10'd1;
                if (w_h_last) begin
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                end
                // Sync and colour are registered together so they stay one pixel behind the counters.
                r_hs     <= !w_hs_act;
                r_vs     <= !w_vs_act;
                r_colour <= w_colour_d;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver: a full-size instance for line timing and a shrunk instance
// checked cycle by cycle against a time-based reference model.
module tb_vga_timing_driver;

    localparam int D   = 2;
    localparam int HV  = 8;
    localparam int HF  = 2;
    localparam int HSY = 3;
    localparam int HB  = 2;
    localparam int VV  = 6;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VB  = 1;
    localparam int HT  = HV + HF + HSY + HB;
    localparam int VT  = VV + VF + VSY + VB;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        addr_mode = 1'b0;
    logic [11:0] rnd_col = 12'h000;
    logic [11:0] col_in;

    logic [9:0]  s_addrh;
    logic [8:0]  s_addrv;
    logic [11:0] s_col;
    logic        s_hs, s_vs, s_fs;

    logic [9:0]  b_addrh;
    logic [8:0]  b_addrv;
    logic [11:0] b_col;
    logic        b_hs, b_vs, b_fs;

    int total = 0;
    int bad   = 0;

    // Reference model state: clocks since reset release and expected registered outputs.
    int          t = 0;
    logic        e_hs = 1'b1;
    logic        e_vs = 1'b1;
    logic [11:0] e_col = 12'h000;
    int          max_h = 0;
    int          max_v = 0;

    always #5 CLK = ~CLK;

    always_comb col_in = addr_mode ? {s_addrh[5:0], s_addrv[5:0]} : rnd_col;

    vga_timing_driver #(
        .CLK_DIV(D), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
    ) u_small (
        .CLK(CLK), .RESET(rst), .COLOUR_IN(col_in), .ADDRH(s_addrh), .ADDRV(s_addrv),
        .COLOUR_OUT(s_col), .HS(s_hs), .VS(s_vs), .FRAME_START(s_fs)
    );

    vga_timing_driver u_big (
        .CLK(CLK), .RESET(rst), .COLOUR_IN(col_in), .ADDRH(b_addrh), .ADDRV(b_addrv),
        .COLOUR_OUT(b_col), .HS(b_hs), .VS(b_vs), .FRAME_START(b_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic tick();
        logic        r;
        logic [11:0] c;
        int          p, h, v;
        logic        border;
        r = rst;
        c = rnd_col;
        @(posedge CLK);
        if (r) begin
            t     = 0;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
            e_col = 12'h000;
        end else begin
            if (t % D == D - 1) begin
                p = t / D;
                h = p % HT;
                v = (p / HT) % VT;
                e_hs = !(h >= HV + HF && h < HV + HF + HSY);
                e_vs = !(v >= VV + VF && v < VV + VF + VSY);
                border = (h == 0) || (h == HV - 1) || (v == 0) || (v == VV - 1);
                if (h < HV && v < VV) begin
                    e_col = addr_mode ? {h[5:0], v[5:0]} : c;
`ifdef VGA_BORDER_EN
                    if (border) e_col = 12'hFFF;
`endif
                end else begin
                    e_col = 12'h000;
                end
            end
            t++;
        end
        #1;
        p = t / D;
        h = p % HT;
        v = (p / HT) % VT;
        chk("addrh", 32'(s_addrh), (h < HV) ? h : 0);
        chk("addrv", 32'(s_addrv), (v < VV) ? v : 0);
        chk("hs", 32'(s_hs), 32'(e_hs));
        chk("vs", 32'(s_vs), 32'(e_vs));
        chk("colour", 32'(s_col), 32'(e_col));
        chk("frame_start", 32'(s_fs),
            32'((t % D == D - 1) && (h == HT - 1) && (v == VT - 1)));
        if (32'(s_addrh) > max_h) max_h = 32'(s_addrh);
        if (32'(s_addrv) > max_v) max_v = 32'(s_addrv);
        rnd_col = 12'($urandom);
    endtask

    initial begin
        int fall1, fall2, lowcnt, abccnt, vslow, fscnt, n_rst;
        logic prev_hs;

        // Full-size line timing and blanking from reset release.
        rst     = 1'b1;
        rnd_col = 12'hABC;
        repeat (3) @(posedge CLK);
        #1 rst = 1'b0;
        fall1 = -1; fall2 = -1; lowcnt = 0; abccnt = 0; vslow = 0; fscnt = 0;
        prev_hs = 1'b1;
        for (int n = 1; n <= 6600; n++) begin
            @(posedge CLK);
            #1;
            if (n <= 3200 && b_col == 12'hABC) abccnt++;
            if (b_hs == 1'b0 && prev_hs == 1'b1) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (b_hs == 1'b0 && fall2 < 0) lowcnt++;
            if (b_vs != 1'b1) vslow++;
            if (b_fs != 1'b0) fscnt++;
            prev_hs = b_hs;
        end
        chk("big_hs_first_fall", fall1, 2628);
        chk("big_hs_period", fall2 - fall1, 3200);
        chk("big_hs_low_width", lowcnt, 384);
        chk("big_visible_colour_clks", abccnt, 2560);
        chk("big_vs_idle_early", vslow, 0);
        chk("big_frame_start_idle", fscnt, 0);

        // Shrunk instance against the reference model.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (200) tick();

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (317) tick();

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                n_rst = $urandom_range(1, 3);
                repeat (n_rst) tick();
                rst = 1'b0;
            end
            tick();
        end

        // Address-derived colour over more than two frames.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr_mode = 1'b1;
        max_h = 0;
        max_v = 0;
        repeat (2 * HT * VT * D + 20) tick();
        chk("addrh_sweep_max", max_h, HV - 1);
        chk("addrv_sweep_max", max_v, VV - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
